// File: rtl/cacheline_adapter.sv
// Cache dfp-port responder: turns each 256-bit line read/write into a 4-beat burst
// on the burst-memory port. One line transaction is in flight at a time.
module cacheline_adapter #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned BEAT_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           i_dfp_addr,
    input  logic                  i_dfp_read,
    input  logic                  i_dfp_write,
    input  logic [LINE_WIDTH-1:0] i_dfp_wdata,
    output logic [LINE_WIDTH-1:0] o_dfp_rdata,
    output logic                  o_dfp_resp,
    output logic [31:0]           o_bmem_addr,
    output logic                  o_bmem_read,
    output logic                  o_bmem_write,
    output logic [BEAT_WIDTH-1:0] o_bmem_wdata,
    input  logic                  i_bmem_ready,
    input  logic [31:0]           i_bmem_raddr,
    input  logic [BEAT_WIDTH-1:0] i_bmem_rdata,
    input  logic                  i_bmem_rvalid
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BEATS  = LINE_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W  = $clog2(LINE_WIDTH / 8);
    localparam int unsigned LAST   = BEATS - 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR_DATA,
        DONE,
        GAP
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [LINE_WIDTH-1:0] r_line;
    logic [LINE_WIDTH-1:0] r_rdata;
    logic                  r_resp;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [ADDR_W-1:0]     w_addr_nxt;
    logic [LINE_WIDTH-1:0] w_line_nxt;
    logic [LINE_WIDTH-1:0] w_rdata_nxt;
    logic                  w_resp_nxt;
    logic                  w_bmem_read;
    logic                  w_bmem_write;
    logic                  w_beat_ok;
    logic                  w_unused_offset;

    // Line offset bits are dropped: bursts are always line aligned.
    assign w_unused_offset = ^i_dfp_addr[OFF_W-1:0];

    // Next-state and datapath; command strobes depend on this cycle's i_bmem_ready.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_line_nxt   = r_line;
        w_rdata_nxt  = r_rdata;
        w_resp_nxt   = 1'b0;
        w_bmem_read  = 1'b0;
        w_bmem_write = 1'b0;
        w_beat_ok    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_dfp_write) begin
                    w_addr_nxt  = {i_dfp_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    w_line_nxt  = i_dfp_wdata;
                    w_cnt_nxt   = '0;
                    w_state_nxt = WR_DATA;
                end else if (i_dfp_read) begin
                    w_addr_nxt  = {i_dfp_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                    w_cnt_nxt   = '0;
                    w_state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                if (i_bmem_ready) begin
                    w_bmem_read = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                w_beat_ok = i_bmem_rvalid && (i_bmem_raddr == r_addr);
                if (w_beat_ok) begin
                    w_line_nxt[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH] = i_bmem_rdata;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(LAST)) begin
                        w_rdata_nxt = w_line_nxt;
                        w_resp_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            WR_DATA: begin
                // Only the first beat waits for ready; the rest stream back to back.
                w_bmem_write = i_bmem_ready || (r_cnt != '0);
                if (w_bmem_write) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(LAST)) begin
                        w_resp_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE:    w_state_nxt = GAP;
            GAP:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_line  <= '0;
            r_rdata <= '0;
            r_resp  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_line  <= w_line_nxt;
            r_rdata <= w_rdata_nxt;
            r_resp  <= w_resp_nxt;
        end
    end

    assign o_dfp_rdata  = r_rdata;
    assign o_dfp_resp   = r_resp;
    assign o_bmem_addr  = r_addr;
    assign o_bmem_read  = w_bmem_read;
    assign o_bmem_write = w_bmem_write;
    assign o_bmem_wdata = r_line[int'(r_cnt)*BEAT_WIDTH +: BEAT_WIDTH];

endmodule
